// File: rtl/p_pack.sv
// p_pack: registered pipe packer.
//
// Takes the discrete fields of a pipe transfer (start, stop, data, valid)
// and drives them as one packed pipe bus. When the consumer stalls, a
// one-entry holding register keeps the offered word so it is replayed
// rather than lost.
//
// Parameters:
//   Data_w    payload width (1..64)
//   StartStop 1 = bus carries start/stop framing bits, 0 = no framing
//   Pipe_w    derived packed bus width, do not override
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-low
//   in_start   first word of a message
//   in_stop    last word of a message
//   in_data    payload
//   in_valid   producer offers a word
//   in_ready   block can take a word this cycle
//   pipe_out   {ready, valid, [stop, start,] data}
//   out_ready  consumer accepts the word on pipe_out this cycle
module p_pack #(
  parameter int Data_w    = 8,
  parameter int StartStop = 1,
  parameter int Pipe_w    = Data_w + 2*StartStop + 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_start,
  input  logic              in_stop,
  input  logic [Data_w-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [Pipe_w-1:0] pipe_out,
  input  logic              out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [Data_w-1:0] held_data_q, held_data_d;
  logic              capture;
  logic              held_valid;
  logic [Data_w-1:0] out_data;
  logic              out_valid;

  // A word is captured only when it is offered in EMPTY and the consumer
  // is not taking it at this edge; otherwise it simply passes through.
  assign held_valid = (state_q == HELD);
  assign capture    = !held_valid && in_valid && !out_ready;

  always_comb begin
    state_d     = state_q;
    held_data_d = held_data_q;
    case (state_q)
      EMPTY: begin
        if (capture) begin
          state_d     = HELD;
          held_data_d = in_data;
        end
      end
      HELD: begin
        if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      held_data_q <= '0;
    end else begin
      state_q     <= state_d;
      held_data_q <= held_data_d;
    end
  end

  // Output side: the holding register wins whenever it is occupied, and the
  // producer is told to wait until the held word has been consumed.
  always_comb begin
    in_ready  = !held_valid;
    out_valid = held_valid ? 1'b1 : in_valid;
    out_data  = held_valid ? held_data_q : in_data;
  end

  generate
    if (StartStop != 0) begin : g_framing
      logic held_start_q, held_start_d;
      logic held_stop_q, held_stop_d;
      logic out_start, out_stop;

      always_comb begin
        held_start_d = held_start_q;
        held_stop_d  = held_stop_q;
        if (capture) begin
          held_start_d = in_start;
          held_stop_d  = in_stop;
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          held_start_q <= 1'b0;
          held_stop_q  <= 1'b0;
        end else begin
          held_start_q <= held_start_d;
          held_stop_q  <= held_stop_d;
        end
      end

      always_comb begin
        out_start = held_valid ? held_start_q : in_start;
        out_stop  = held_valid ? held_stop_q  : in_stop;
      end

      assign pipe_out = {out_ready, out_valid, out_stop, out_start, out_data};
    end else begin : g_no_framing
      assign pipe_out = {out_ready, out_valid, out_data};
    end
  endgenerate

endmodule

// File: tb/tb_p_pack.sv
module tb_p_pack;

  localparam int DW = 8;
  localparam int PW = DW + 4;

  logic          clock;
  logic          reset;
  logic          in_start;
  logic          in_stop;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] pipe_out;
  logic          out_ready;

  int tests = 0;
  int fails = 0;
  logic [9:0] sb_q[$];

  p_pack #(.Data_w(DW), .StartStop(1)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_start (in_start),
    .in_stop  (in_stop),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pipe_out (pipe_out),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish before 200000");
    $fatal(1);
  end

  // Scoreboard step: record upstream transfers, check downstream ones just
  // before the edge, then advance to 1 time unit past the rising edge.
  task automatic tick();
    logic [9:0] exp;
    #1;
    if (in_valid && in_ready) sb_q.push_back({in_stop, in_start, in_data});
    if (pipe_out[10] && out_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: got word %h, expected none", pipe_out[9:0]);
      end else begin
        exp = sb_q.pop_front();
        if (pipe_out[9:0] !== exp) begin
          fails++;
          $display("FAIL sb_word: got %h, expected %h", pipe_out[9:0], exp);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_start = 1'b0; in_stop = 1'b0;
    in_data = 8'h33; in_valid = 1'b1; out_ready = 1'b0;
    #2;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
    tests++;
    if (pipe_out[10:0] !== {1'b1, 2'b00, 8'h33}) begin
      fails++; $display("FAIL rst_passthru: got %h, expected %h", pipe_out[10:0], {1'b1, 2'b00, 8'h33});
    end
    @(posedge clock); #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_no_capture: got %b, expected 1", in_ready); end
    in_valid = 1'b0;
    #1;
    tests++;
    if (pipe_out[10] !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, expected 0", pipe_out[10]); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_pass_through();
    out_ready = 1'b1; in_valid = 1'b1; in_start = 1'b0; in_stop = 1'b0; in_data = 8'h55;
    #1;
    tests++;
    if (pipe_out !== {1'b1, 1'b1, 2'b00, 8'h55}) begin
      fails++; $display("FAIL pass_bus: got %h, expected %h", pipe_out, {1'b1, 1'b1, 2'b00, 8'h55});
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || pipe_out[10] !== 1'b0) begin
      fails++; $display("FAIL pass_empty: got ready=%b valid=%b, expected 1 0", in_ready, pipe_out[10]);
    end
  endtask

  task automatic test_stall_capture();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h45;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    #1;
    tests++;
    if (pipe_out[10:0] !== {1'b1, 2'b00, 8'h45} || in_ready !== 1'b0) begin
      fails++; $display("FAIL stall_hold: got bus=%h ready=%b, expected %h 0", pipe_out[10:0], in_ready, {1'b1, 2'b00, 8'h45});
    end
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    tests++;
    if (pipe_out[7:0] !== 8'h45) begin
      fails++; $display("FAIL stall_ignore_in: got %h, expected 45", pipe_out[7:0]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ready_glitch();
    out_ready = 1'b1;
    #2;
    out_ready = 1'b0;
    tick();
    tests++;
    if (pipe_out[10:0] !== {1'b1, 2'b00, 8'h45} || in_ready !== 1'b0) begin
      fails++; $display("FAIL glitch_hold: got bus=%h ready=%b, expected %h 0", pipe_out[10:0], in_ready, {1'b1, 2'b00, 8'h45});
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (pipe_out[10] !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL glitch_release: got valid=%b ready=%b, expected 0 1", pipe_out[10], in_ready);
    end
  endtask

  task automatic test_valid_indecision();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    #1;
    tests++;
    if (pipe_out[10:0] !== {1'b1, 2'b00, 8'hAA}) begin
      fails++; $display("FAIL indec_aa: got %h, expected %h", pipe_out[10:0], {1'b1, 2'b00, 8'hAA});
    end
    in_valid = 1'b0;
    #1;
    tests++;
    if (pipe_out[10] !== 1'b0) begin fails++; $display("FAIL indec_drop: got %b, expected 0", pipe_out[10]); end
    #1;
    in_valid = 1'b1; in_data = 8'h0A;
    #1;
    tests++;
    if (pipe_out[10:0] !== {1'b1, 2'b00, 8'h0A}) begin
      fails++; $display("FAIL indec_0a: got %h, expected %h", pipe_out[10:0], {1'b1, 2'b00, 8'h0A});
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL indec_no_capture: got %b, expected 1", in_ready); end
  endtask

  task automatic test_framing();
    out_ready = 1'b0; in_valid = 1'b1; in_start = 1'b1; in_stop = 1'b0; in_data = 8'h01;
    tick();
    in_start = 1'b0; in_stop = 1'b1; in_data = 8'h02;
    #1;
    tests++;
    if (pipe_out[10:0] !== {1'b1, 1'b0, 1'b1, 8'h01}) begin
      fails++; $display("FAIL frame_start: got %h, expected %h", pipe_out[10:0], {1'b1, 1'b0, 1'b1, 8'h01});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    tests++;
    if (pipe_out[10:0] !== {1'b1, 1'b1, 1'b0, 8'h02}) begin
      fails++; $display("FAIL frame_stop: got %h, expected %h", pipe_out[10:0], {1'b1, 1'b1, 1'b0, 8'h02});
    end
    in_valid = 1'b0; in_stop = 1'b0;
    out_ready = 1'b1;
    tick();
    tests++;
    if (sb_q.size() != 0) begin fails++; $display("FAIL frame_drain: got %0d pending, expected 0", sb_q.size()); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (pipe_out[10] !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL async_rst: got valid=%b ready=%b, expected 0 1", pipe_out[10], in_ready);
    end
    sb_q.delete();
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (pipe_out[10] !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL async_rst_after: got valid=%b ready=%b, expected 0 1", pipe_out[10], in_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      tests++;
      if (in_ready !== (sb_q.size() == 0)) begin
        fails++; $display("FAIL b2b_ready[%0d]: got %b, expected %b", i, in_ready, sb_q.size() == 0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = 8'($urandom);
      in_start  = 1'($urandom);
      in_stop   = 1'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    tests++;
    if (sb_q.size() != 0) begin fails++; $display("FAIL b2b_drain: got %0d pending, expected 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall_capture();
    test_ready_glitch();
    test_valid_indecision();
    test_framing();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p_pack.md
# p_pack

Registered pipe packer. Accepts the individual fields of a pipe transfer (start, stop, data, valid) from a producer and drives them as one packed pipe bus toward a downstream consumer. It contains a one-entry holding register, so a word offered while the consumer is stalled is captured and replayed instead of lost. It sits at the output of any block that produces discrete fields and must feed a standard pipe.

## Interface

Parameters:
- Data_w, 8: payload width in bits (1..64).
- StartStop, 1: 1 = bus carries start/stop framing bits; 0 = framing omitted, in_start/in_stop ignored.
- Pipe_w, Data_w + 2*StartStop + 2: derived packed bus width; do not override.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears holding register immediately.
- in_start  in  1  first word of a message.
- in_stop  in  1  last word of a message.
- in_data  in  Data_w  payload.
- in_valid  in  1  producer offers a word.
- in_ready  out  1  block can take a word this cycle.
- pipe_out  out  Pipe_w  packed bus. Bits [Data_w-1:0] data; [Data_w] start, [Data_w+1] stop (only if StartStop); next bit valid; MSB ready (copy of out_ready).
- out_ready  in  1  consumer accepts the word on pipe_out this cycle.

## Operation

- State: held_valid (1 bit), held_start, held_stop, held_data.
- EMPTY (held_valid=0): combinational pass-through. pipe_out fields = in_* fields, valid = in_valid. in_ready = 1.
- HELD (held_valid=1): pipe_out fields = held_* fields, valid = 1. in_ready = 0. Input fields are ignored.
- EMPTY -> HELD: at clock edge when in_valid=1 and out_ready=0. Capture in_start/in_stop/in_data.
- HELD -> EMPTY: at clock edge when out_ready=1. The held word is consumed.
- HELD stays HELD while out_ready=0, whatever in_valid is.
- An upstream transfer occurs when in_valid & in_ready. A downstream transfer occurs when pipe_out.valid & out_ready.
- When StartStop=0, held_start/held_stop are not implemented and the bus has no framing bits.
- Data is never modified. No word is dropped or duplicated.

## Timing

- Reset (asserted, async): held_valid=0. Outputs follow inputs combinationally: in_ready=1 and pipe_out.valid = in_valid. Held fields are cleared to 0.
- Latency: 0 cycles in EMPTY. A captured word appears from the holding register starting the cycle after capture.
- out_ready may toggle within a cycle. Only its value at the clock edge decides capture or release. pipe_out stays stable while HELD.
- Boundary: if in_valid and out_ready are both 1 in EMPTY, the word passes through and nothing is captured.
- Boundary: a reset mid-HELD discards the held word.
- Boundary: in_valid dropping while in EMPTY drops pipe_out.valid in the same cycle. This is permitted, since no transfer occurred.

## Test plan

- Pass-through: out_ready=1, in = valid, start=0, stop=0, 0x55 -> pipe_out same cycle data 0x55, valid=1. Remains EMPTY after the edge.
- Stall capture: out_ready drops to 0 with 0x45 valid, then clock; then in_valid=0 -> pipe_out still shows 0x45, valid=1, and in_ready=0.
- Ready glitch: while HELD, pulse out_ready 1 then back to 0 mid-cycle -> 0x45 is still held after the edge. Set out_ready=1 across the edge -> next cycle valid=0 and in_ready=1.
- Valid indecision: out_ready=1, in_valid toggles 1 (0xAA), 0, 0, then 1 (0x0A) within a cycle -> pipe_out tracks the inputs combinationally and nothing is captured.
- Framing: start=1 with 0x01, stalled, then stop=1 with 0x02 -> start and stop bits are preserved through capture and replay.
- Async reset while HELD -> valid=0 and in_ready=1 immediately, without waiting for a clock.
